// File: rtl/message_stream_combiner.sv
// Merges a sample-word stream and a framed debug-message stream onto one
// output word stream. Messages are buffered until complete, then sent
// contiguously at a message/data boundary; malformed or overflowing messages
// are dropped as a unit and flagged on the sticky error output.
module message_stream_combiner #(
  parameter int WIDTH      = 32,
  parameter int DATA_DEPTH = 64,
  parameter int MSG_DEPTH  = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_nd,
  input  logic [WIDTH-1:0] in_msg,
  input  logic             in_msg_nd,
  output logic [WIDTH-1:0] out_data,
  output logic             out_nd,
  output logic             error
);

  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int MAW = $clog2(MSG_DEPTH);
  localparam int LW  = 10;  // header length field width

  localparam logic [DAW:0] DATA_FULL = (DAW + 1)'(DATA_DEPTH);
  localparam logic [MAW:0] MSG_FULL  = (MAW + 1)'(MSG_DEPTH);

  typedef enum logic [1:0] {EXPECT_HDR, PAYLOAD, DISCARD} parse_e;
  typedef enum logic       {IDLE, SEND}                   out_e;

  logic [WIDTH-1:0] data_mem [DATA_DEPTH];
  logic [WIDTH-1:0] msg_mem  [MSG_DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [DAW:0]     d_wr_q, d_wr_d, d_rd_q, d_rd_d;
  logic [MAW:0]     m_wr_q, m_wr_d, m_cm_q, m_cm_d, m_rd_q, m_rd_d;
  parse_e           p_state_q, p_state_d;
  logic [LW-1:0]    rem_q, rem_d;
  out_e             o_state_q, o_state_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_nd_q, out_nd_d;
  logic             error_q, error_d;

  logic             d_we, d_err, m_we, m_err;
  logic             data_full, msg_full;
  logic [LW-1:0]    in_len, head_len;
  logic [WIDTH-1:0] m_head;

  assign data_full = (d_wr_q - d_rd_q) == DATA_FULL;
  assign msg_full  = (m_wr_q - m_rd_q) == MSG_FULL;
  assign in_len    = in_msg[WIDTH-2 -: LW];
  assign m_head    = msg_mem[m_rd_q[MAW-1:0]];
  assign head_len  = m_head[WIDTH-2 -: LW];

  // Data FIFO write side: sample words must have MSB clear and find room.
  always_comb begin
    d_we   = in_nd && !in_data[WIDTH-1] && !data_full;
    d_err  = in_nd && (in_data[WIDTH-1] || data_full);
    d_wr_d = d_we ? d_wr_q + 1'b1 : d_wr_q;
  end

  // Message parser: writes words, commits whole messages, rolls back on overflow.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    m_wr_d    = m_wr_q;
    m_cm_d    = m_cm_q;
    p_state_d = p_state_q;
    rem_d     = rem_q;
    m_we      = 1'b0;
    m_err     = 1'b0;
    if (in_msg_nd) begin
      unique case (p_state_q)
        EXPECT_HDR: begin
          if (!in_msg[WIDTH-1]) begin
            m_err = 1'b1;
          end else if (msg_full) begin
            m_err  = 1'b1;
            m_wr_d = m_cm_q;
            if (in_len != '0) begin
              p_state_d = DISCARD;
              rem_d     = in_len;
            end
          end else begin
            m_we   = 1'b1;
            m_wr_d = m_wr_q + 1'b1;
            if (in_len == '0) begin
              m_cm_d = m_wr_q + 1'b1;
            end else begin
              p_state_d = PAYLOAD;
              rem_d     = in_len;
            end
          end
        end
        PAYLOAD: begin
          rem_d = rem_q - 1'b1;
          if (msg_full) begin
            m_err     = 1'b1;
            m_wr_d    = m_cm_q;
            p_state_d = (rem_q == LW'(1)) ? EXPECT_HDR : DISCARD;
          end else begin
            m_we   = 1'b1;
            m_wr_d = m_wr_q + 1'b1;
            if (rem_q == LW'(1)) begin
              m_cm_d    = m_wr_q + 1'b1;
              p_state_d = EXPECT_HDR;
            end
          end
        end
        DISCARD: begin
          rem_d = rem_q - 1'b1;
          if (rem_q == LW'(1)) p_state_d = EXPECT_HDR;
        end
        default: p_state_d = EXPECT_HDR;
      endcase
    end
  end

  // Output FSM: committed messages win at boundaries, data fills other slots.
  always_comb begin
    o_state_d  = o_state_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_nd_d   = 1'b0;
    d_rd_d     = d_rd_q;
    m_rd_d     = m_rd_q;
    unique case (o_state_q)
      IDLE: begin
        if (m_rd_q != m_cm_q) begin
          out_data_d = m_head;
          out_nd_d   = 1'b1;
          m_rd_d     = m_rd_q + 1'b1;
          if (head_len != '0) begin
            cnt_d     = head_len;
            o_state_d = SEND;
          end
        end else if (d_rd_q != d_wr_q) begin
          out_data_d = data_mem[d_rd_q[DAW-1:0]];
          out_nd_d   = 1'b1;
          d_rd_d     = d_rd_q + 1'b1;
        end
      end
      SEND: begin
        out_data_d = m_head;
        out_nd_d   = 1'b1;
        m_rd_d     = m_rd_q + 1'b1;
        cnt_d      = cnt_q - 1'b1;
        if (cnt_q == LW'(1)) o_state_d = IDLE;
      end
      default: o_state_d = IDLE;
    endcase
    error_d = error_q || d_err || m_err;
  end

  // FIFO storage writes.
  // NOTE: storage arrays are deliberately not reset; the pointers alone define
  // which entries are valid, and leaving them unreset lets them map to RAM.
  always_ff @(posedge clk) begin
    if (d_we) data_mem[d_wr_q[DAW-1:0]] <= in_data;
    if (m_we) msg_mem[m_wr_q[MAW-1:0]]  <= in_msg;
  end

  // State and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_wr_q     <= '0;
      d_rd_q     <= '0;
      m_wr_q     <= '0;
      m_cm_q     <= '0;
      m_rd_q     <= '0;
      p_state_q  <= EXPECT_HDR;
      rem_q      <= '0;
      o_state_q  <= IDLE;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_nd_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed above, independent of statement order.
      d_wr_q     <= d_wr_d;
      d_rd_q     <= d_rd_d;
      m_wr_q     <= m_wr_d;
      m_cm_q     <= m_cm_d;
      m_rd_q     <= m_rd_d;
      p_state_q  <= p_state_d;
      rem_q      <= rem_d;
      o_state_q  <= o_state_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_nd_q   <= out_nd_d;
      error_q    <= error_d;
    end
  end

  assign out_data = out_data_q;
  assign out_nd   = out_nd_q;
  assign error    = error_q;

endmodule
